// File: rtl/mpsub_pkg.sv
// Shared constants and types for the pipelined multi-precision subtractor.
// The operand is split into NBLK borrow-select blocks; the top block holds the leftover TOPW bits.
package mpsub_pkg;

  localparam int WIDTH = 1027;
  localparam int BLOCK = 128;
  localparam int NBLK  = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int TOPW  = WIDTH - (NBLK - 1) * BLOCK;

  typedef logic [BLOCK-1:0] blk_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
  } res_t;

endpackage

// File: rtl/mpsubtractor_pipe_if.sv
// Valid/ready operand and result channels of the pipelined subtractor.
// master drives operands and consumes results; slave is the subtractor side.
interface mpsubtractor_pipe_if;
  import mpsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow
  );

endinterface

// File: rtl/sub_blk_sel.sv
// One borrow-select block: precomputes a - b for both possible borrow-ins.
// d0/bo0 assume no borrow-in (a + ~b + 1), d1/bo1 assume a borrow-in (a + ~b).
module sub_blk_sel #(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d0,
  output logic         bo0,
  output logic [W-1:0] d1,
  output logic         bo1
);

  logic [W:0] sum0;
  logic [W:0] sum1;

  // A carry-out of the two's-complement add means no borrow.
  assign sum0 = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
  assign sum1 = {1'b0, a} + {1'b0, ~b};

  assign d0  = sum0[W-1:0];
  assign bo0 = ~sum0[W];
  assign d1  = sum1[W-1:0];
  assign bo1 = ~sum1[W];

endmodule

// File: rtl/mpsubtractor_pipe.sv
// Two-stage block borrow-select subtractor with elastic valid/ready on both sides.
// Build option MPSUB_CONDSUB_EN: out_diff returns the minuend when the subtraction borrows.
module mpsubtractor_pipe
  import mpsub_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  mpsubtractor_pipe_if.slave  bus
);

  logic s1_valid_q;
  logic out_valid_q;
  logic s1_adv;
  logic accept;

  logic [WIDTH-1:0]     d0_d, d0_q;
  logic [WIDTH-1:BLOCK] d1_d, d1_q;
  logic [NBLK-1:0]      bo0_d, bo0_q;
  logic [NBLK-1:1]      bo1_d, bo1_q;

  logic [WIDTH-1:0] diff_s2;
  logic             borrow_s2;
  logic [WIDTH-1:0] result_s2;

  logic [WIDTH-1:0] out_diff_q;
  logic             out_borrow_q;

  // ---------------------------------------------------------------- handshake
  assign s1_adv      = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign accept      = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------- per-block datapath
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLOCK;
    localparam int W  = (k == NBLK - 1) ? TOPW : BLOCK;

    logic br;

    if (k == 0) begin : g_lsb
      logic [W:0] sum0;

      assign sum0           = {1'b0, bus.in_a[LO +: W]} + {1'b0, ~bus.in_b[LO +: W]} + (W+1)'(1);
      assign d0_d[LO +: W]  = sum0[W-1:0];
      assign bo0_d[k]       = ~sum0[W];

      assign br               = bo0_q[k];
      assign diff_s2[LO +: W] = d0_q[LO +: W];
    end else begin : g_sel
      sub_blk_sel #(.W(W)) u_blk (
        .a   (bus.in_a[LO +: W]),
        .b   (bus.in_b[LO +: W]),
        .d0  (d0_d[LO +: W]),
        .bo0 (bo0_d[k]),
        .d1  (d1_d[LO +: W]),
        .bo1 (bo1_d[k])
      );

      // Ripple only the per-block borrow; the wide differences are merely selected.
      assign br               = g_blk[k-1].br ? bo1_q[k] : bo0_q[k];
      assign diff_s2[LO +: W] = g_blk[k-1].br ? d1_q[LO +: W] : d0_q[LO +: W];
    end
  end

  assign borrow_s2 = g_blk[NBLK-1].br;

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // NOTE: wide datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      bo0_q <= bo0_d;
      bo1_q <= bo1_d;
    end
  end

`ifdef MPSUB_CONDSUB_EN
  logic [WIDTH-1:0] a_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.in_a;
    end
  end

  assign result_s2 = borrow_s2 ? a_q : diff_s2;
`else
  assign result_s2 = diff_s2;
`endif

  // ---------------------------------------------------------------- stage 2 / output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_diff_q   <= '0;
      out_borrow_q <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q  <= 1'b1;
      out_diff_q   <= result_s2;
      out_borrow_q <= borrow_s2;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_diff   = out_diff_q;
  assign bus.out_borrow = out_borrow_q;

endmodule

// File: tb/tb_mpsubtractor_pipe.sv
// Self-checking bench for mpsubtractor_pipe: scoreboard of modelled results popped on each output handshake.
// Covers reset, latency, block-boundary borrows, back-to-back streaming, backpressure and mid-operation reset.
module tb_mpsubtractor_pipe;
  import mpsub_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  mpsubtractor_pipe_if bus ();

  mpsubtractor_pipe dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  res_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_out    = 0;
  string phase    = "reset";

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] x;
    int               top;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      x   = got ^ exp;
      top = -1;
      for (int i = 0; i < WIDTH; i++) if (x[i] !== 1'b0) top = i;
      $display("FAIL %s got=%h exp=%h (low 128 bits shown, top differing bit %0d)",
               tag, got[127:0], exp[127:0], top);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit subtraction, independent of the block structure.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    res_t           e;
    r        = {1'b0, a} - {1'b0, b};
    e.borrow = r[WIDTH];
`ifdef MPSUB_CONDSUB_EN
    e.diff   = r[WIDTH] ? a : r[WIDTH-1:0];
`else
    e.diff   = r[WIDTH-1:0];
`endif
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    logic [33*32-1:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return t[WIDTH-1:0];
  endfunction

  // Call aligned at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check({phase, "_accept_timeout"}, WIDTH'(bus.in_ready), WIDTH'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    check({phase, "_drained"}, WIDTH'(sb.size()), WIDTH'(0));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    res_t e;
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check({phase, "_unexpected_out"}, WIDTH'(bus.out_valid), WIDTH'(0));
      end else begin
        e = sb.pop_front();
        check({phase, "_diff"},   bus.out_diff,            e.diff);
        check({phase, "_borrow"}, WIDTH'(bus.out_borrow),  WIDTH'(e.borrow));
        n_out++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired in phase %s", phase);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b, v;
    logic [WIDTH-1:0] bp_a[3];
    logic [WIDTH-1:0] bp_b[3];
    int               base;
    int               run;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    resetn        = 1'b0;

    #1;
    check("rst_out_valid",  WIDTH'(bus.out_valid),  WIDTH'(0));
    check("rst_in_ready",   WIDTH'(bus.in_ready),   WIDTH'(1));
    check("rst_out_diff",   bus.out_diff,           WIDTH'(0));
    check("rst_out_borrow", WIDTH'(bus.out_borrow), WIDTH'(0));
    #12 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single operation and latency.
    phase = "single";
    send(WIDTH'(5), WIDTH'(3));
    @(negedge clk);
    check("single_lat1", WIDTH'(bus.out_valid), WIDTH'(0));
    @(negedge clk);
    check("single_lat2", WIDTH'(bus.out_valid), WIDTH'(1));
    check("single_val",  bus.out_diff,          WIDTH'(2));
    wait_drain();

    // Directed boundary cases.
    phase = "ripple";
    send('0, WIDTH'(1));
    wait_drain();

    phase = "blk128";
    v = '0; v[128] = 1'b1;
    send(v, WIDTH'(1));
    wait_drain();

    phase = "blk896";
    v = '0; v[896] = 1'b1;
    send(v, WIDTH'(1));
    wait_drain();

    phase = "equal";
    a = rand_op();
    send(a, a);
    wait_drain();

    phase = "max";
    send('1, '0);
    wait_drain();

    // Back-to-back streaming of 16 operations.
    phase = "b2b";
    base  = n_out;
    run   = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          a = rand_op();
          b = (i == 5) ? a : rand_op();
          send(a, b);
        end
      end
      begin
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          if (bus.out_valid) run++;
          else if (run > 0) break;
        end
      end
    join
    check("b2b_run", WIDTH'(run), WIDTH'(16));
    wait_drain();
    check("b2b_count", WIDTH'(n_out - base), WIDTH'(16));

    // Backpressure: three operations offered while the sink stalls for five cycles.
    phase = "bp";
    base  = n_out;
    for (int i = 0; i < 3; i++) begin
      bp_a[i] = rand_op();
      bp_b[i] = rand_op();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_a = bp_a[i];
      bus.in_b = bp_b[i];
      @(negedge clk);
      check("bp_accept_rdy", WIDTH'(bus.in_ready), WIDTH'(1));
      sb.push_back(model(bp_a[i], bp_b[i]));
      @(posedge clk);
      #1;
    end
    bus.in_a = bp_a[2];
    bus.in_b = bp_b[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_rdy",   WIDTH'(bus.in_ready),   WIDTH'(0));
      check("bp_held_valid", WIDTH'(bus.out_valid),  WIDTH'(1));
      check("bp_held_diff",  bus.out_diff,           sb[0].diff);
      check("bp_held_bor",   WIDTH'(bus.out_borrow), WIDTH'(sb[0].borrow));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", WIDTH'(bus.in_ready), WIDTH'(1));
    sb.push_back(model(bp_a[2], bp_b[2]));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_drain();
    check("bp_count", WIDTH'(n_out - base), WIDTH'(3));

    // Reset with one operation in stage 1 only.
    phase = "rst1";
    send(rand_op(), rand_op());
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst1_out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    check("rst1_in_ready",  WIDTH'(bus.in_ready),  WIDTH'(1));
    sb.delete();
    @(posedge clk);
    #2 resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst1_no_stale", WIDTH'(bus.out_valid), WIDTH'(0));
    end

    // Reset with both stages full under backpressure.
    phase = "rst2";
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(rand_op(), rand_op());
    send(rand_op(), rand_op());
    @(negedge clk);
    check("rst2_pre_valid", WIDTH'(bus.out_valid), WIDTH'(1));
    resetn = 1'b0;
    #1;
    check("rst2_out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    check("rst2_in_ready",  WIDTH'(bus.in_ready),  WIDTH'(1));
    check("rst2_out_diff",  bus.out_diff,          WIDTH'(0));
    sb.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2 resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst2_no_stale", WIDTH'(bus.out_valid), WIDTH'(0));
    end

    // Recovery after reset.
    phase = "recover";
    @(posedge clk);
    #1;
    send(WIDTH'(7), WIDTH'(9));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
